// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one outstanding word request to
// instruction memory and captures returned words into the IF/ID register for decode.
module fetch_unit #(
    parameter int              WORD     = 32,
    parameter logic [WORD-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [WORD-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [WORD-1:0] redirect_pc,
    output logic [WORD-1:0] instr,
    output logic [WORD-1:0] pc_plus4,
    output logic            instr_valid
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD
    } state_t;

    localparam logic [WORD-1:0] FOUR = WORD'(4);

    state_t          state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] fetch_addr_q, fetch_addr_d;
    logic [WORD-1:0] hold_word_q, hold_word_d;
    logic [WORD-1:0] hold_addr_q, hold_addr_d;
    logic [WORD-1:0] instr_q, instr_d;
    logic [WORD-1:0] pc_plus4_q, pc_plus4_d;
    logic            instr_valid_q, instr_valid_d;

    logic [WORD-1:0] target;
    logic            unused_rpc_bits;

    assign target          = {redirect_pc[WORD-1:2], 2'b00};
    assign unused_rpc_bits = ^redirect_pc[1:0];

    // Gated with reset so no request leaks out while the memory is also held in reset.
    assign imem_req    = (state_q == S_REQ) && reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign pc_plus4    = pc_plus4_q;
    assign instr_valid = instr_valid_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_addr_d  = fetch_addr_q;
        hold_word_d   = hold_word_q;
        hold_addr_d   = hold_addr_q;
        instr_d       = instr_q;
        pc_plus4_d    = pc_plus4_q;
        instr_valid_d = instr_valid_q;

        // Decode takes the current word; a load below overrides this.
        if (instr_valid_q && !stall) begin
            instr_valid_d = 1'b0;
        end
        if (redirect) begin
            instr_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = target;
                    // The old-address request was still accepted; its word must be dropped.
                    if (imem_ready) begin
                        state_d = S_DROP;
                    end
                end else if (imem_ready) begin
                    fetch_addr_d = pc_q;
                    pc_d         = pc_q + FOUR;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    if (!instr_valid_q || !stall) begin
                        instr_d       = imem_rdata;
                        pc_plus4_d    = fetch_addr_q + FOUR;
                        instr_valid_d = 1'b1;
                        state_d       = S_REQ;
                    end else begin
                        hold_word_d = imem_rdata;
                        hold_addr_d = fetch_addr_q;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d        = target;
                    hold_word_d = '0;
                    hold_addr_d = '0;
                    state_d     = S_REQ;
                end else if (!stall) begin
                    instr_d       = hold_word_q;
                    pc_plus4_d    = hold_addr_q + FOUR;
                    instr_valid_d = 1'b1;
                    state_d       = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            fetch_addr_q  <= '0;
            hold_word_q   <= '0;
            hold_addr_q   <= '0;
            instr_q       <= '0;
            pc_plus4_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_addr_q  <= fetch_addr_d;
            hold_word_q   <= hold_word_d;
            hold_addr_q   <= hold_addr_d;
            instr_q       <= instr_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_valid_q <= instr_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus with a simple instruction memory whose
// word is addr ^ 32'hA5A5_0000, and a scoreboard of consumed IF/ID entries.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    logic        mem_hold;
    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];
    int          total;
    int          bad;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr      (instr),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the falling edge.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Memory: responds one cycle after acceptance unless mem_hold delays it.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!reset) mem_q.delete();
            if (mem_q.size() != 0 && !mem_hold) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_q.pop_front() ^ KEY;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
            #2;
            if (reset && imem_req && imem_ready) mem_q.push_back(imem_addr);
        end
    end

    // Monitor: every word decode takes (valid, not stalled, not flushed) is scored.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #3;
            if (reset && instr_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc_plus4 %h expected no instruction", pc_plus4);
                end else begin
                    a = exp_q.pop_front();
                    check("ifid_instr", instr, a ^ KEY);
                    check("ifid_pc_plus4", pc_plus4, a + 32'd4);
                end
            end
        end
    end

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        imem_ready  = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_hold    = 1'b0;

        next_cycle();
        next_cycle();
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h0);
        check("rst_addr", imem_addr, 32'h0040_0000);

        // Release reset with a zero-wait memory.
        reset      = 1'b1;
        imem_ready = 1'b1;
        exp_q.push_back(32'h0040_0000);
        #1;
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0040_0000);
        next_cycle();
        check("wait_req", imem_req, 1'b0);
        check("wait_valid", instr_valid, 1'b0);
        next_cycle();
        check("first_valid", instr_valid, 1'b1);
        check("first_pc_plus4", pc_plus4, 32'h0040_0004);
        check("first_instr", instr, 32'hA5E5_0000);
        check("second_addr", imem_addr, 32'h0040_0004);
        check("second_req", imem_req, 1'b1);
        exp_q.push_back(32'h0040_0004);
        exp_q.push_back(32'h0040_0008);
        next_cycle();
        next_cycle();

        // Stall while a response returns: the word goes into the hold buffer.
        stall = 1'b1;
        next_cycle();
        next_cycle();
        check("hold_req", imem_req, 1'b0);
        check("hold_valid", instr_valid, 1'b1);
        check("hold_pc_plus4", pc_plus4, 32'h0040_0008);
        check("hold_instr", instr, 32'hA5E5_0004);
        next_cycle();
        check("hold2_req", imem_req, 1'b0);
        check("hold2_pc_plus4", pc_plus4, 32'h0040_0008);
        stall = 1'b0;
        next_cycle();
        check("unhold_pc_plus4", pc_plus4, 32'h0040_000C);
        check("unhold_valid", instr_valid, 1'b1);
        check("resume_req", imem_req, 1'b1);
        check("resume_addr", imem_addr, 32'h0040_000C);
        imem_ready = 1'b0;
        next_cycle();

        // Redirect during WAIT with the response delayed: it must be dropped.
        imem_ready = 1'b1;
        mem_hold   = 1'b1;
        next_cycle();
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0103;
        check("wait2_req", imem_req, 1'b0);
        next_cycle();
        redirect = 1'b0;
        mem_hold = 1'b0;
        check("drop_req", imem_req, 1'b0);
        check("drop_valid", instr_valid, 1'b0);
        next_cycle();
        check("drop2_req", imem_req, 1'b0);
        check("drop2_valid", instr_valid, 1'b0);
        next_cycle();
        check("after_drop_valid", instr_valid, 1'b0);
        check("after_drop_req", imem_req, 1'b1);
        check("after_drop_addr", imem_addr, 32'h0040_0100);

        // Redirect in REQ on the same cycle the old request is accepted.
        imem_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0200;
        next_cycle();
        redirect   = 1'b0;
        imem_ready = 1'b0;
        check("req_redir_drop_req", imem_req, 1'b0);
        next_cycle();
        check("req_redir_valid", instr_valid, 1'b0);
        check("req_redir_req", imem_req, 1'b1);
        check("req_redir_addr", imem_addr, 32'h0040_0200);
        imem_ready = 1'b1;
        next_cycle();
        imem_ready = 1'b0;
        next_cycle();
        check("target_valid", instr_valid, 1'b1);
        check("target_pc_plus4", pc_plus4, 32'h0040_0204);

        // Fill HOLD under stall, then redirect: everything is flushed.
        stall      = 1'b1;
        imem_ready = 1'b1;
        next_cycle();
        imem_ready = 1'b0;
        next_cycle();
        check("hold3_req", imem_req, 1'b0);
        check("hold3_valid", instr_valid, 1'b1);
        check("hold3_pc_plus4", pc_plus4, 32'h0040_0204);
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0300;
        next_cycle();
        redirect = 1'b0;
        stall    = 1'b0;
        check("hold_redir_valid", instr_valid, 1'b0);
        check("hold_redir_req", imem_req, 1'b1);
        check("hold_redir_addr", imem_addr, 32'h0040_0300);
        imem_ready = 1'b1;
        exp_q.push_back(32'h0040_0300);
        next_cycle();
        imem_ready = 1'b0;
        next_cycle();
        check("refetch_valid", instr_valid, 1'b1);
        check("refetch_pc_plus4", pc_plus4, 32'h0040_0304);

        // Asynchronous reset while a request is outstanding.
        imem_ready = 1'b1;
        mem_hold   = 1'b1;
        next_cycle();
        imem_ready = 1'b0;
        reset      = 1'b0;
        #1;
        check("async_valid", instr_valid, 1'b0);
        check("async_instr", instr, 32'h0);
        check("async_pc_plus4", pc_plus4, 32'h0);
        check("async_req", imem_req, 1'b0);
        check("async_addr", imem_addr, 32'h0040_0000);
        next_cycle();
        mem_hold = 1'b0;
        next_cycle();
        reset      = 1'b1;
        imem_ready = 1'b1;
        exp_q.push_back(32'h0040_0000);
        #1;
        check("rerelease_req", imem_req, 1'b1);
        check("rerelease_addr", imem_addr, 32'h0040_0000);
        next_cycle();
        imem_ready = 1'b0;
        next_cycle();
        check("rerelease_valid", instr_valid, 1'b1);
        check("rerelease_pc_plus4", pc_plus4, 32'h0040_0004);

        // PC wrap from the top of the address space; low target bits are ignored.
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        next_cycle();
        redirect = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_req", imem_req, 1'b1);
        imem_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        next_cycle();
        next_cycle();
        check("wrap_valid", instr_valid, 1'b1);
        check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        check("wrap_next_addr", imem_addr, 32'h0000_0000);
        check("wrap_next_req", imem_req, 1'b1);
        imem_ready = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();

        check("scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of decode. Holds the PC and issues word requests to instruction memory over a request/response handshake, allowing one outstanding request. Captures returned words into the IF/ID register that feeds decode (instr, pc_plus4, instr_valid). Honours decode back-pressure (stall) and branch/jump redirects (redirect, redirect_pc).

Parameters:
WORD, 32, datapath/address width
RESET_PC, 32'h0040_0000, PC loaded on reset (MIPS text base)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  request valid to instruction memory
imem_addr  out  WORD  request word address, bits[1:0] always 00
imem_ready  in  1  memory accepts request this cycle (handshake = imem_req & imem_ready)
imem_rvalid  in  1  response word valid (one cycle, exactly one per accepted request)
imem_rdata  in  WORD  response instruction word
stall  in  1  decode cannot accept a new instruction; IF/ID holds
redirect  in  1  flush and refetch from redirect_pc
redirect_pc  in  WORD  redirect target; bits[1:0] ignored, forced 00
instr  out  WORD  IF/ID instruction
pc_plus4  out  WORD  IF/ID fetch address + 4
instr_valid  out  1  IF/ID holds a valid instruction

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=REQ, instr=0 (NOP), pc_plus4=0, instr_valid=0, hold buffer empty, fetch_addr=0. imem_req is forced to 0 while reset is low.
- Internal regs: pc (next fetch address), fetch_addr (address of the outstanding request), hold buffer (1 entry: word + addr).
- imem_req=1 only in REQ; imem_addr=pc. Before acceptance, imem_addr may change only on redirect.
- FSM states: REQ, WAIT, DROP, HOLD.
- REQ:
  - redirect & imem_ready: the old-address request is accepted; pc<=redirect_pc; ->DROP.
  - redirect & !imem_ready: pc<=redirect_pc; stay REQ.
  - imem_ready: fetch_addr<=pc; pc<=pc+4 (mod 2^32); ->WAIT.
- WAIT:
  - redirect (with or without imem_rvalid): pc<=redirect_pc. If imem_rvalid, discard the word and ->REQ; otherwise ->DROP.
  - imem_rvalid & (!instr_valid | !stall): load instr<=imem_rdata, pc_plus4<=fetch_addr+4, instr_valid<=1; ->REQ.
  - imem_rvalid & instr_valid & stall: store word and fetch_addr into hold; ->HOLD.
- DROP: wait for imem_rvalid, discard the word, ->REQ. A redirect in DROP updates pc and stays in DROP.
- HOLD: no new requests.
  - !stall: IF/ID<=hold contents, instr_valid=1; ->REQ.
  - redirect: clear hold; pc<=redirect_pc; ->REQ.
- IF/ID consumption: if instr_valid & !stall and nothing loads that cycle, then instr_valid<=0. instr and pc_plus4 keep their last values.
- Redirect has priority over stall and response capture. Every redirect clears instr_valid on the same edge.
- Throughput: with imem_ready=1 and rvalid one cycle after acceptance, the unit delivers one instruction every 2 cycles. First instr_valid appears 2 cycles after reset release, given zero-wait memory.
- Reset asserted mid-request: state returns to REQ. A response still in flight is not tracked; the memory model must be reset with this unit.
- PC wrap: 32'hFFFF_FFFC+4 = 0, no error.

Test Plan:
- Reset release, memory with ready=1 and 1-cycle rvalid returning addr^32'hA5A5_0000 -> first imem_addr=0x00400000; instr_valid rises at cycle 2 with pc_plus4=0x00400004; next fetch addr 0x00400004.
- Hold stall=1 while instr_valid=1 and a response returns -> FSM in HOLD, imem_req=0, IF/ID unchanged; drop stall -> held word appears next cycle with correct pc_plus4, fetch resumes.
- redirect=1, redirect_pc=0x00400103 during WAIT with no rvalid -> DROP; late response discarded, instr_valid=0; next imem_addr=0x00400100.
- redirect in REQ on the same cycle as imem_ready -> the accepted old-address word is dropped; next request is to redirect_pc; no stale instr_valid.
- redirect together with stall=1 and HOLD occupied -> hold cleared, instr_valid=0, refetch from target.
- Assert reset low during WAIT -> outputs return to reset values immediately (async); pc=0x00400000 after release.
